// File: rtl/mem_sys_pkg.sv
// Shared memory-subsystem constants and the fill arbiter state encoding.
package mem_sys_pkg;

    localparam int MEM_LAT       = 4;
    localparam int WORDS_PER_BLK = 8;
    localparam int BLK_OFF_W     = 4;
    localparam int WORD_IDX_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL_I = 2'd1,
        ST_FILL_D = 2'd2,
        ST_WRITE  = 2'd3
    } state_e;

endpackage

// File: rtl/fill_arb_select.sv
// Grant decision for the fill arbiter: returns the state to enter from IDLE.
// Define FILL_ARB_RR_EN to alternate D-side and I-side on simultaneous requests.
module fill_arb_select
    import mem_sys_pkg::*;
(
`ifdef FILL_ARB_RR_EN
    input  logic   clk,
    input  logic   rst,
`endif
    input  logic   i_sample,
    input  logic   i_wr_req,
    input  logic   i_d_miss,
    input  logic   i_i_miss,
    output state_e o_grant
);

`ifdef FILL_ARB_RR_EN
    logic r_last_d;
    logic w_d_side;
    logic w_pick_d;

    assign w_d_side = i_wr_req | i_d_miss;
    // On a tie the side that won last time yields; stores still beat misses within D.
    assign w_pick_d = w_d_side & (~i_i_miss | ~r_last_d);

    always_comb begin
        o_grant = ST_IDLE;
        if (i_sample) begin
            if (w_pick_d) begin
                o_grant = i_wr_req ? ST_WRITE : ST_FILL_D;
            end else if (i_i_miss) begin
                o_grant = ST_FILL_I;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (i_sample && o_grant != ST_IDLE) begin
            r_last_d <= (o_grant != ST_FILL_I);
        end
    end
`else
    always_comb begin
        o_grant = ST_IDLE;
        if (i_sample) begin
            if (i_wr_req) begin
                o_grant = ST_WRITE;
            end else if (i_d_miss) begin
                o_grant = ST_FILL_D;
            end else if (i_i_miss) begin
                o_grant = ST_FILL_I;
            end
        end
    end
`endif

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one memory port between I/D block fills and D-side write-through stores.
// Optional FILL_ARB_RR_EN switches the grant policy to D/I round-robin.
module cache_fill_arbiter #(
    parameter int MEM_LAT       = mem_sys_pkg::MEM_LAT,
    parameter int WORDS_PER_BLK = mem_sys_pkg::WORDS_PER_BLK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic        d_wr_ack,
    output logic        i_fill_we,
    output logic        d_fill_we,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        busy
);
    import mem_sys_pkg::*;

    state_e                r_state;
    state_e                w_next;
    state_e                w_grant;
    logic [3:0]            r_issue_cnt;
    logic [3:0]            r_ret_cnt;
    logic [15-BLK_OFF_W:0] r_base;
    logic                  w_idle;
    logic                  w_fill;
    logic                  w_issue;
    logic                  w_rv;
    logic                  w_done;
    logic                  w_unused;

    // Byte offsets inside a block never matter; the latency is set by the memory itself.
    assign w_unused = ^{i_miss_addr[BLK_OFF_W-1:0], d_miss_addr[BLK_OFF_W-1:0]} ^ (MEM_LAT > 0);

    assign w_idle  = (r_state == ST_IDLE);
    assign w_fill  = (r_state == ST_FILL_I) || (r_state == ST_FILL_D);
    assign w_issue = w_fill && (r_issue_cnt < 4'(WORDS_PER_BLK));
    assign w_rv    = w_fill && mem_rvalid;
    assign w_done  = w_rv && (r_ret_cnt == 4'(WORDS_PER_BLK - 1));

    fill_arb_select u_select (
`ifdef FILL_ARB_RR_EN
        .clk      (clk),
        .rst      (rst),
`endif
        .i_sample (w_idle),
        .i_wr_req (d_wr_req),
        .i_d_miss (d_miss),
        .i_i_miss (i_miss),
        .o_grant  (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:              w_next = w_grant;
            ST_FILL_I, ST_FILL_D: if (w_done) w_next = ST_IDLE;
            ST_WRITE:             w_next = ST_IDLE;
            default:              w_next = ST_IDLE;
        endcase
    end

    // Counters restart in IDLE; the block base is captured only on the grant edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_base      <= '0;
        end else if (w_idle) begin
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            if (w_grant == ST_FILL_I) begin
                r_base <= i_miss_addr[15:BLK_OFF_W];
            end else if (w_grant == ST_FILL_D) begin
                r_base <= d_miss_addr[15:BLK_OFF_W];
            end
        end else begin
            if (w_issue) r_issue_cnt <= r_issue_cnt + 4'd1;
            if (w_rv)    r_ret_cnt   <= r_ret_cnt + 4'd1;
        end
    end

    always_comb begin
        busy        = !w_idle;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        d_wr_ack    = 1'b0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        fill_word   = '0;
        fill_data   = '0;
        unique case (r_state)
            ST_FILL_I, ST_FILL_D: begin
                mem_en = w_issue;
                if (w_issue) begin
                    mem_addr = {r_base, r_issue_cnt[WORD_IDX_W-1:0], 1'b0};
                end
                i_fill_we   = w_rv && (r_state == ST_FILL_I);
                d_fill_we   = w_rv && (r_state == ST_FILL_D);
                i_fill_done = w_done && (r_state == ST_FILL_I);
                d_fill_done = w_done && (r_state == ST_FILL_D);
                if (w_rv) begin
                    fill_word = r_ret_cnt[WORD_IDX_W-1:0];
                    fill_data = mem_rdata;
                end
            end
            ST_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_wr_addr;
                mem_wdata = d_wr_data;
                d_wr_ack  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed scoreboard bench for cache_fill_arbiter with a fixed-latency memory model.
// Expected grant order follows FILL_ARB_RR_EN when it is defined.
module tb_cache_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
    logic        d_wr_ack, i_fill_we, d_fill_we, i_fill_done, d_fill_done;
    logic [2:0]  fill_word;
    logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr, mem_rvalid, busy;

    logic [3:0]  pipeV = '0;
    logic [15:0] pipeD [4];
    logic        strayRv = 1'b0;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t sbQ[$];
    exp_t monE;
    int   checks = 0;
    int   errors = 0;

    cache_fill_arbiter dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .fill_word(fill_word), .fill_data(fill_data),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Four-cycle read pipeline; it keeps draining through reset like a real memory.
    always @(posedge clk) begin
        pipeV    <= {pipeV[2:0], mem_en && !mem_wr};
        pipeD[0] <= mem_addr ^ 16'hA5A5;
        for (int k = 1; k < 4; k++) pipeD[k] <= pipeD[k-1];
    end
    assign mem_rvalid = pipeV[3] | strayRv;
    assign mem_rdata  = pipeV[3] ? pipeD[3] : (strayRv ? 16'hDEAD : 16'h0000);

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic dm, input logic im,
                                 input logic [15:0] wa, input logic [15:0] wd,
                                 input logic [15:0] da, input logic [15:0] ia);
        d_wr_req = wr; d_miss = dm; i_miss = im;
        d_wr_addr = wa; d_wr_data = wd; d_miss_addr = da; i_miss_addr = ia;
    endtask

    task automatic pushFill(input int kind, input logic [15:0] base);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.kind = kind;
            e.addr = base + 16'(2 * k);
            e.data = e.addr ^ 16'hA5A5;
            sbQ.push_back(e);
        end
    endtask

    task automatic pushWrite(input logic [15:0] addr, input logic [15:0] data);
        exp_t e;
        e.kind = 3; e.addr = addr; e.data = data;
        sbQ.push_back(e);
    endtask

    task automatic waitIdle(input string tag);
        int c = 0;
        do begin
            @(posedge clk); #3;
            c++;
        end while (busy && c < 200);
        checkOutput({tag, "_idle_timeout"}, 16'(busy), 16'h0);
        checkOutput({tag, "_sb_empty"}, 16'(sbQ.size()), 16'h0);
    endtask

    always @(negedge clk) begin
        if (i_fill_we || d_fill_we || d_wr_ack) begin
            if (sbQ.size() == 0) begin
                checkOutput("sb_unexpected", 16'({i_fill_we, d_fill_we, d_wr_ack}), 16'h0);
            end else begin
                monE = sbQ.pop_front();
                checkOutput("sb_kind", 16'({i_fill_we, d_fill_we, d_wr_ack}),
                            monE.kind == 1 ? 16'h4 : (monE.kind == 2 ? 16'h2 : 16'h1));
                if (monE.kind == 3) begin
                    checkOutput("wr_addr", mem_addr, monE.addr);
                    checkOutput("wr_data", mem_wdata, monE.data);
                    checkOutput("wr_strobes", 16'({mem_en, mem_wr}), 16'h3);
                end else begin
                    checkOutput("fill_word", 16'(fill_word), 16'(monE.addr[3:1]));
                    checkOutput("fill_data", fill_data, monE.data);
                    checkOutput("fill_done", 16'({i_fill_done, d_fill_done}),
                                monE.addr[3:1] != 3'd7 ? 16'h0 : (monE.kind == 1 ? 16'h2 : 16'h1));
                end
            end
        end
    end

    initial begin
        int c;
        logic wrOpen, dOpen, iOpen;

        #1 rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_busy", 16'(busy), 16'h0);
        checkOutput("rst_mem_en", 16'(mem_en), 16'h0);
        checkOutput("rst_mem_addr", mem_addr, 16'h0);
        checkOutput("rst_outs", 16'({d_wr_ack, i_fill_we, d_fill_we, fill_word}), 16'h0);
        rst = 1'b0;

        // Single I fill with exact per-cycle timing.
        @(posedge clk); #1;
        applyStimulus(0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h1236);
        pushFill(1, 16'h1230);
        #2 checkOutput("t1_c0_busy", 16'(busy), 16'h0);
        for (int cyc = 1; cyc <= 13; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) i_miss = 1'b0;
            #2;
            checkOutput($sformatf("t1_en_c%0d", cyc), 16'(mem_en), 16'(cyc <= 8));
            checkOutput($sformatf("t1_addr_c%0d", cyc), mem_addr,
                        cyc <= 8 ? 16'h1230 + 16'(2 * (cyc - 1)) : 16'h0);
            checkOutput($sformatf("t1_we_c%0d", cyc), 16'(i_fill_we), 16'(cyc >= 5 && cyc <= 12));
            checkOutput($sformatf("t1_done_c%0d", cyc), 16'(i_fill_done), 16'(cyc == 12));
            checkOutput($sformatf("t1_busy_c%0d", cyc), 16'(busy), 16'(cyc <= 12));
        end

        // Write, D miss and I miss together.
        @(posedge clk); #1;
        applyStimulus(1, 1, 1, 16'h4000, 16'hBEEF, 16'h2008, 16'h3000);
        pushWrite(16'h4000, 16'hBEEF);
`ifdef FILL_ARB_RR_EN
        pushFill(1, 16'h3000);
        pushFill(2, 16'h2000);
`else
        pushFill(2, 16'h2000);
        pushFill(1, 16'h3000);
`endif
        wrOpen = 1'b1; dOpen = 1'b1; iOpen = 1'b1;
        c = 0;
        while ((wrOpen || dOpen || iOpen || busy) && c < 200) begin
            @(posedge clk); #3;
            c++;
            if (c == 1) checkOutput("t2_ack_c1", 16'(d_wr_ack), 16'h1);
            if (d_wr_ack) begin d_wr_req = 1'b0; wrOpen = 1'b0; end
            if (mem_en && !mem_wr && mem_addr[15:4] == 12'h200) begin d_miss = 1'b0; dOpen = 1'b0; end
            if (mem_en && !mem_wr && mem_addr[15:4] == 12'h300) begin i_miss = 1'b0; iOpen = 1'b0; end
        end
        checkOutput("t2_timeout", 16'(c < 200), 16'h1);
        checkOutput("t2_sb_empty", 16'(sbQ.size()), 16'h0);

        // Reset in the middle of a D fill.
        @(posedge clk); #1;
        applyStimulus(0, 1, 0, 16'h0, 16'h0, 16'h5550, 16'h0);
        pushFill(2, 16'h5550);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) d_miss = 1'b0;
        end
        sbQ.delete();
        rst = 1'b1;
        #2;
        checkOutput("t3_rst_busy", 16'(busy), 16'h0);
        checkOutput("t3_rst_mem", 16'({mem_en, mem_wr}), 16'h0);
        checkOutput("t3_rst_addr", mem_addr, 16'h0);
        checkOutput("t3_rst_we", 16'({i_fill_we, d_fill_we}), 16'h0);
        checkOutput("t3_rst_data", fill_data, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #3;
            checkOutput($sformatf("t3_drop_c%0d", cyc), 16'({d_fill_we, d_fill_done, busy}), 16'h0);
        end
        @(posedge clk); #1;
        applyStimulus(0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h0A10);
        pushFill(1, 16'h0A10);
        @(posedge clk); #1;
        i_miss = 1'b0;
        waitIdle("t3_refill");

        // D miss withdrawn and readdressed after the grant.
        @(posedge clk); #1;
        applyStimulus(0, 1, 0, 16'h0, 16'h0, 16'h7770, 16'h0);
        pushFill(2, 16'h7770);
        @(posedge clk); #1;
        d_miss = 1'b0;
        d_miss_addr = 16'h1110;
        waitIdle("t4_latched");

        // Stray read returns while idle.
        @(posedge clk); #1;
        strayRv = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            #2;
            checkOutput($sformatf("t5_we_c%0d", cyc), 16'({i_fill_we, d_fill_we, i_fill_done, d_fill_done}), 16'h0);
            checkOutput($sformatf("t5_busy_c%0d", cyc), 16'(busy), 16'h0);
            checkOutput($sformatf("t5_data_c%0d", cyc), fill_data, 16'h0);
            @(posedge clk); #1;
        end
        strayRv = 1'b0;
        #2 checkOutput("t5_after_busy", 16'(busy), 16'h0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
